// File: rtl/ram_dma_copy.sv
// Block-copy bus master: moves N bytes or words between RAM offsets, one read plus one write per unit.
// Latency: 2 cycles per unit with grant held. Backpressure: holds RD/WR while bus_gnt is low.
module ram_dma_copy #(
    parameter logic [15:0] BOUND_U = 16'h0400,
    parameter logic [15:0] BOUND_L = 16'h0200,
    parameter int          CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      src_addr,
    input  logic [15:0]      dst_addr,
    input  logic [CNT_W-1:0] xfer_cnt,
    input  logic             xfer_bw,
    input  logic             abort,
    input  logic             bus_gnt,
    input  logic [15:0]      ram_out,
    output logic             bus_req,
    output logic [15:0]      ram_addr,
    output logic [15:0]      ram_Din,
    output logic             ram_RW,
    output logic             BW,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] remaining
);

    localparam int EW = ((CNT_W > 16) ? CNT_W : 16) + 2;
    localparam logic [EW-1:0]    SIZE_W  = EW'(BOUND_U - BOUND_L);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [15:0]      src_q, src_d;
    logic [15:0]      dst_q, dst_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             bw_q, bw_d;
    logic [15:0]      data_q, data_d;
    logic             err_q, err_d;

    logic [15:0]      step;
    logic [EW-1:0]    span;
    logic [EW-1:0]    src_end;
    logic [EW-1:0]    dst_end;
    logic             range_bad;

    // End offsets are one past the last byte touched; widened so nothing wraps.
    always_comb begin
        span      = xfer_bw ? EW'(xfer_cnt) : (EW'(xfer_cnt) << 1);
        src_end   = EW'(src_addr) + span;
        dst_end   = EW'(dst_addr) + span;
        range_bad = (src_end > SIZE_W) || (dst_end > SIZE_W);
        step      = bw_q ? 16'd1 : 16'd2;
    end

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        bw_d     = bw_q;
        data_d   = data_q;
        err_d    = err_q;
        bus_req  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        ram_addr = 16'h0000;
        ram_Din  = 16'h0000;
        ram_RW   = 1'b0;
        BW       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d = src_addr;
                    dst_d = dst_addr;
                    rem_d = xfer_cnt;
                    bw_d  = xfer_bw;
                    err_d = 1'b0;
                    if (xfer_cnt == '0) begin
                        state_d = S_DONE;
                    end else if (range_bad) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                bus_req  = 1'b1;
                busy     = 1'b1;
                ram_addr = src_q;
                BW       = bw_q;
                if (abort) begin
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    data_d  = bw_q ? {8'h00, ram_out[7:0]} : ram_out;
                    state_d = S_WR;
                end
            end
            S_WR: begin
                bus_req  = 1'b1;
                busy     = 1'b1;
                ram_addr = dst_q;
                ram_Din  = data_q;
                BW       = bw_q;
                // Reset is combinational here so a reset cycle can never commit a write.
                ram_RW   = bus_gnt && !abort && !rst;
                if (abort) begin
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    src_d   = src_q + step;
                    dst_d   = dst_q + step;
                    rem_d   = rem_q - ONE_CNT;
                    state_d = (rem_q == ONE_CNT) ? S_DONE : S_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            bw_q    <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            bw_q    <= bw_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign remaining = rem_q;
    assign err       = err_q;

endmodule
